pipe_cla_addsub: RTL and testbench
==================================

Name: pipe_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the datapath ALU; replaces the single-cycle 4-bit group adder chain for wide operands.
- Operand is split into slices of SLICE bits. Each slice is one pipeline stage built from 4-bit lookahead groups.
- Carry is registered between stages; operands are skewed on entry and sums deskewed on exit.
- Valid/ready handshake on both sides; also produces carry, overflow, zero and negative flags.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of SLICE
SLICE, 8, bits resolved per pipeline stage; must be a multiple of 4
NSTG, WIDTH/SLICE (derived, localparam), pipeline depth and latency in cycles

Ports:
clk  in  1  clock, rising edge
clr  in  1  asynchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in; used only when sub=0
sub  in  1  1 = A - B (B inverted, carry-in forced 1); 0 = A + B + cin
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result
cout  out  1  carry out of MSB; for sub, 1 = no borrow
ovf  out  1  signed overflow
zero  out  1  sum == 0
neg  out  1  sum[WIDTH-1]

Behaviour:
- Reset (clr=1, async): all stage valid bits 0; out_valid=0; sum, cout, ovf, zero, neg all 0.
  - Asserting mid-operation discards every in-flight beat; no partial result ever appears.
  - in_ready is 1 while clr=1 and after clr deasserts.
- Global advance: adv = !out_valid | out_ready; in_ready = adv.
  - When adv=0, every stage register holds, including valid bits, skew/deskew data and carries.
- Accept: the beat enters when in_valid & in_ready.
  - Stage 0 resolves slice 0 with carry-in c0 = sub ? 1 : cin and B' = sub ? ~b : b.
  - Bits above slice 0 enter the skew buffer.
- Stage k (1..NSTG-1): resolves slice k from its skewed A/B' bits and the registered carry of stage k-1.
  - Within a slice, 4-bit groups use group generate/propagate lookahead; there is no ripple across groups.
- Completed slices are carried forward in the deskew buffer. After stage NSTG-1, the full sum is registered to the outputs.
- Latency: result is valid exactly NSTG cycles after acceptance when out_ready stays 1 (default: 4).
- Throughput: one beat per cycle with no stalls. Bubbles propagate as valid=0 stages and do not block.
- Flags, registered with sum:
  - cout = carry out of the MSB.
  - ovf = carry into MSB XOR carry out of MSB.
  - neg = sum MSB.
  - zero is accumulated per stage as a running AND of slice-is-zero, so no WIDTH-bit compare is needed at the output.
- Output holds sum/flags stable while out_valid & !out_ready.
- Simultaneous pop and push while full is allowed: the pipeline shifts and the new beat is accepted the same cycle.
- sub and cin are sampled only at acceptance and travel with the beat. Mixed add/sub beats back-to-back are legal.
- Wrap-around: the sum is modulo 2^WIDTH. Overflow is flagged only, never saturated.
- When out_valid=0, the output values are don't-care except after reset, when they are 0.

Test Plan:
- Reset/idle: assert clr for 3 cycles, then release -> out_valid=0, sum=0, all flags 0, in_ready=1.
- Basic add with cin: a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0 -> after 4 cycles sum=0x0000_0100, cout=0, ovf=0, zero=0, neg=0. Repeat with cin=1 -> sum=0x0000_0101.
- Full carry chain across all slices:
  - a=0xFFFF_FFFF, b=0x0000_0001, add -> sum=0, cout=1, zero=1, ovf=0.
  - a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, ovf=1, neg=1, cout=0.
- Subtract: a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0, neg=1. a=7, b=7, sub=1 -> sum=0, zero=1, cout=1. a=0x8000_0000, b=1, sub=1 -> ovf=1.
- Back-pressure and streaming:
  - Send 8 random beats back-to-back with out_ready toggling 1,0,0,1,…
  - Required: results match a reference model in order, with no loss or duplication.
  - in_ready tracks adv; output is stable while stalled.
  - Throughput is 1 beat/cycle whenever out_ready=1.
- Reset mid-flight: accept 3 beats, then pulse clr asynchronously between edges -> out_valid drops to 0 immediately. None of the 3 results ever appears. The next accepted beat produces a correct result 4 cycles later.

Source files
------------

// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SLICE-bit slice resolved per stage, NSTG-cycle latency.
// Global stall: every stage holds when the output is valid and not accepted.
module pipe_cla_addsub #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NSTG = WIDTH / SLICE;
  localparam int NGRP = SLICE / 4;

  // a/b hold the not-yet-consumed operand bits, s collects finished slices,
  // c is the carry into the next slice, cm the carry into the latest slice MSB.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             cm;
    logic             z;
  } stg_t;

  typedef struct packed {
    logic [SLICE-1:0] s;
    logic             co;
    logic             cm;
  } slc_t;

  function automatic slc_t cla_slice(input logic [SLICE-1:0] x,
                                     input logic [SLICE-1:0] y,
                                     input logic             ci);
    logic [SLICE-1:0] g, p, c;
    logic [NGRP-1:0]  gg, gp;
    logic [NGRP:0]    gc;
    logic             t;
    slc_t             r;
    g = x & y;
    p = x ^ y;
    for (int j = 0; j < NGRP; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (&p[4*j+1 +: 3] & g[4*j]);
    end
    // Group carries as flat sum-of-products over all lower groups, no group-to-group ripple.
    for (int j = 0; j <= NGRP; j++) begin
      t = ci;
      for (int m = 0; m < j; m++) t = t & gp[m];
      gc[j] = t;
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t = t & gp[m];
        gc[j] = gc[j] | t;
      end
    end
    for (int j = 0; j < NGRP; j++) begin
      for (int n = 0; n < 4; n++) begin
        t = gc[j];
        for (int m = 0; m < n; m++) t = t & p[4*j+m];
        c[4*j+n] = t;
        for (int i = 0; i < n; i++) begin
          t = g[4*j+i];
          for (int m = i + 1; m < n; m++) t = t & p[4*j+m];
          c[4*j+n] = c[4*j+n] | t;
        end
      end
    end
    r.s  = p ^ c;
    r.co = gc[NGRP];
    r.cm = c[SLICE-1];
    return r;
  endfunction

  logic adv;
  stg_t in_stg;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    in_stg     = '0;
    in_stg.vld = in_valid;
    in_stg.a   = a;
    in_stg.b   = sub ? ~b : b;
    in_stg.c   = sub | cin;
    in_stg.z   = 1'b1;
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    stg_t stg_in, stg_d, stg_q;
    slc_t res;

    if (k == 0) begin : g_first
      assign stg_in = in_stg;
    end else begin : g_rest
      assign stg_in = g_stg[k-1].stg_q;
    end

    always_comb begin
      res   = cla_slice(stg_in.a[k*SLICE +: SLICE], stg_in.b[k*SLICE +: SLICE], stg_in.c);
      stg_d = stg_in;
      stg_d.s[k*SLICE +: SLICE] = res.s;
      stg_d.c  = res.co;
      stg_d.cm = res.cm;
      stg_d.z  = stg_in.z & ~|res.s;
    end

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        stg_q <= '0;
      end else if (adv) begin
        stg_q <= stg_d;
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].stg_q.vld;
  assign sum       = g_stg[NSTG-1].stg_q.s;
  assign cout      = g_stg[NSTG-1].stg_q.c;
  assign ovf       = g_stg[NSTG-1].stg_q.cm ^ g_stg[NSTG-1].stg_q.c;
  assign zero      = g_stg[NSTG-1].stg_q.z;
  assign neg       = g_stg[NSTG-1].stg_q.s[WIDTH-1];

  // Operand copies are fully consumed by the last stage.
  logic unused_skew;
  assign unused_skew = ^{g_stg[NSTG-1].stg_q.a, g_stg[NSTG-1].stg_q.b};

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Randomized and directed bench for pipe_cla_addsub against an arithmetic reference model.
module tb_pipe_cla_addsub;
  localparam int W    = 32;
  localparam int NSTG = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic         clk = 1'b0;
  logic         clr;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, cout, ovf, zero, neg;

  int checks = 0;
  int errors = 0;
  int tick_n = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         co, ov, z, n;
    int           t;
    bit           lat;
  } exp_t;

  exp_t        sb_q[$];
  bit          stall_prev = 1'b0;
  logic [35:0] held;
  bit          lat_mode = 1'b0;

  pipe_cla_addsub #(.WIDTH(W), .SLICE(8)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    exp_t        e;
    longint      sx, sy, r;
    logic [W:0]  u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      e.s  = x - y;
      e.co = (x >= y);
      r    = sx - sy;
    end else begin
      u    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      e.s  = u[W-1:0];
      e.co = u[W];
      r    = sx + sy + longint'(c);
    end
    e.ov  = (r > SMAX) || (r < SMIN);
    e.z   = (e.s == '0);
    e.n   = e.s[W-1];
    e.t   = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Called just after inputs are driven at a falling edge; ends on the next falling edge.
  task automatic tick(input bit use_ovr, input exp_t ovr, output bit acc);
    exp_t e;
    #1;
    chk("in_ready_adv", 64'(in_ready), 64'(!out_valid || out_ready));
    if (stall_prev && out_valid)
      chk("stall_stable", 64'({sum, cout, ovf, zero, neg}), 64'(held));
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sum",  64'(sum),  64'(e.s));
        chk("cout", 64'(cout), 64'(e.co));
        chk("ovf",  64'(ovf),  64'(e.ov));
        chk("zero", 64'(zero), 64'(e.z));
        chk("neg",  64'(neg),  64'(e.n));
        if (e.lat) chk("latency", 64'(tick_n - e.t), 64'(NSTG));
      end
    end
    stall_prev = out_valid && !out_ready;
    held       = {sum, cout, ovf, zero, neg};
    acc        = in_valid && in_ready;
    if (acc) begin
      e     = use_ovr ? ovr : model(a, b, cin, sub);
      e.t   = tick_n;
      e.lat = lat_mode;
      sb_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    tick_n++;
  endtask

  task automatic drain();
    bit   acc;
    exp_t dummy;
    dummy = '{default: 0};
    for (int i = 0; i < 40 && sb_q.size() > 0; i++) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick(1'b0, dummy, acc);
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 4))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] a, b;
    logic         c, s;
    logic [W-1:0] es;
    logic         co, ov, z, n;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit   acc;
    exp_t ovr, dummy;
    int   cnt;
    dummy = '{default: 0};
    vecs[0] = '{32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_00FF, 32'h1, 1'b1, 1'b0, 32'h0000_0101, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h5,         32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h7,         32'h7, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'h3,         32'h1, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h0,         32'h0, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0};

    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_flags", 64'({cout, ovf, zero, neg}), 64'd0);
    chk("rst_in_ready_after", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Directed vectors, back to back, full throughput and exact latency.
    lat_mode  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].c; sub = vecs[i].s;
      ovr = '{vecs[i].es, vecs[i].co, vecs[i].ov, vecs[i].z, vecs[i].n, 0, 1'b0};
      tick(1'b1, ovr, acc);
      chk("accept_dir", 64'(acc), 64'd1);
    end
    drain();

    // Eight random beats with out_ready pattern 1,0,0,1,...
    lat_mode = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      a = rand_op(); b = rand_op(); cin = 1'($urandom); sub = 1'($urandom);
      acc = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin
        out_ready = (cnt % 4 == 0) || (cnt % 4 == 3);
        cnt++;
        tick(1'b0, dummy, acc);
      end
      chk("accept_stream", 64'(acc), 64'd1);
    end
    drain();

    // Random bubbles and random backpressure.
    for (int i = 0; i < 60; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = rand_op(); b = rand_op(); cin = 1'($urandom); sub = 1'($urandom);
      tick(1'b0, dummy, acc);
    end
    drain();

    // Reset while three beats are in flight.
    lat_mode  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      tick(1'b0, dummy, acc);
    end
    in_valid = 1'b0;
    tick(1'b0, dummy, acc);
    chk("pre_clr_valid", 64'(out_valid), 64'd1);
    #2 clr = 1'b1;
    #1;
    chk("clr_out_valid", 64'(out_valid), 64'd0);
    chk("clr_sum", 64'(sum), 64'd0);
    chk("clr_flags", 64'({cout, ovf, zero, neg}), 64'd0);
    chk("clr_in_ready", 64'(in_ready), 64'd1);
    #1 clr = 1'b0;
    sb_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) tick(1'b0, dummy, acc);
    in_valid = 1'b1;
    a = 32'h1234_5678; b = 32'h0FED_CBA9; cin = 1'b0; sub = 1'b1;
    tick(1'b0, dummy, acc);
    chk("accept_post_clr", 64'(acc), 64'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
